// File: rtl/pll_lock_rst_seq.sv
// PLL-lock gated reset sequencer: syncs lock/user reset, qualifies lock, holds SYS_RST, then releases.
// Optional macro PLL_LOSS_CNT_EN adds the saturating LOSS_CNT[7:0] lock-loss event counter.
module pll_lock_rst_seq #(
    parameter int unsigned LOCK_REQ    = 1,
    parameter int unsigned LOCK_FILTER = 4,
    parameter int unsigned RST_HOLD    = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PLL_LOCKED,
    input  logic       USR_RSTN,
    input  logic       CLR_LOST,
    output logic       SYS_RST,
    output logic       RST_DONE,
    output logic       LOCK_LOST,
    output logic       STDY_RST_REQ,
`ifdef PLL_LOSS_CNT_EN
    output logic [7:0] LOSS_CNT,
`endif
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_FILTER    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    localparam logic [15:0] FILT_LAST = 16'(LOCK_FILTER - 1);
    localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);

    logic [1:0]  lock_sync_q;
    logic [1:0]  urst_sync_q;
    logic        lock_s;
    logic        urst_n;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sys_rst_q, sys_rst_d;
    logic        done_q, done_d;
    logic        lost_q, lost_d;
    logic        stdy_q, stdy_d;
    logic        lost_set;
`ifdef PLL_LOSS_CNT_EN
    logic [7:0]  loss_cnt_q, loss_cnt_d;
`endif

    // Two-flop synchronisers; user reset idles deasserted (1).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lock_sync_q <= '0;
            urst_sync_q <= '1;
        end else begin
            lock_sync_q <= {lock_sync_q[0], PLL_LOCKED};
            urst_sync_q <= {urst_sync_q[0], USR_RSTN};
        end
    end

    assign lock_s = lock_sync_q[1];
    assign urst_n = urst_sync_q[1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lost_set = 1'b0;
        if (!urst_n) begin
            // User reset outranks everything, including lock-loss reporting.
            state_d = ST_RESET;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
                ST_WAIT_LOCK: begin
                    cnt_d = '0;
                    if (LOCK_REQ == 0) begin
                        state_d = ST_HOLD;
                    end else if (lock_s) begin
                        state_d = ST_FILTER;
                    end
                end
                ST_FILTER: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == FILT_LAST) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                    if ((LOCK_REQ != 0) && !lock_s) begin
                        state_d  = ST_WAIT_LOCK;
                        lost_set = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs decoded from the next state so they change on the same edge as STATE.
        sys_rst_d = (state_d != ST_RUN);
        done_d    = (state_d == ST_RUN);
        lost_d    = lost_set | (lost_q & ~CLR_LOST);
        stdy_d    = lost_set;
`ifdef PLL_LOSS_CNT_EN
        loss_cnt_d = (lost_set && (loss_cnt_q != 8'hFF)) ? loss_cnt_q + 8'd1 : loss_cnt_q;
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            sys_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            lost_q     <= 1'b0;
            stdy_q     <= 1'b0;
`ifdef PLL_LOSS_CNT_EN
            loss_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sys_rst_q  <= sys_rst_d;
            done_q     <= done_d;
            lost_q     <= lost_d;
            stdy_q     <= stdy_d;
`ifdef PLL_LOSS_CNT_EN
            loss_cnt_q <= loss_cnt_d;
`endif
        end
    end

    assign STATE        = state_q;
    assign SYS_RST      = sys_rst_q;
    assign RST_DONE     = done_q;
    assign LOCK_LOST    = lost_q;
    assign STDY_RST_REQ = stdy_q;
`ifdef PLL_LOSS_CNT_EN
    assign LOSS_CNT     = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Directed self-checking bench for pll_lock_rst_seq (LOCK_REQ=1 and LOCK_REQ=0 instances).
module tb_pll_lock_rst_seq;

    logic       CLK;
    logic       RST;
    logic       PLL_LOCKED;
    logic       USR_RSTN;
    logic       CLR_LOST;

    logic       sys_rst, rst_done, lock_lost, stdy;
    logic [2:0] state;
    logic       sys_rst0, rst_done0, lock_lost0, stdy0;
    logic [2:0] state0;
`ifdef PLL_LOSS_CNT_EN
    logic [7:0] loss_cnt, loss_cnt0;
`endif

    int total = 0;
    int bad   = 0;

    pll_lock_rst_seq #(.LOCK_REQ(1), .LOCK_FILTER(4), .RST_HOLD(8)) dut (
        .CLK(CLK), .RST(RST), .PLL_LOCKED(PLL_LOCKED), .USR_RSTN(USR_RSTN), .CLR_LOST(CLR_LOST),
        .SYS_RST(sys_rst), .RST_DONE(rst_done), .LOCK_LOST(lock_lost), .STDY_RST_REQ(stdy),
`ifdef PLL_LOSS_CNT_EN
        .LOSS_CNT(loss_cnt),
`endif
        .STATE(state)
    );

    pll_lock_rst_seq #(.LOCK_REQ(0), .LOCK_FILTER(4), .RST_HOLD(8)) dut0 (
        .CLK(CLK), .RST(RST), .PLL_LOCKED(PLL_LOCKED), .USR_RSTN(USR_RSTN), .CLR_LOST(CLR_LOST),
        .SYS_RST(sys_rst0), .RST_DONE(rst_done0), .LOCK_LOST(lock_lost0), .STDY_RST_REQ(stdy0),
`ifdef PLL_LOSS_CNT_EN
        .LOSS_CNT(loss_cnt0),
`endif
        .STATE(state0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic apply_reset(input logic locked);
        RST        = 1'b1;
        PLL_LOCKED = locked;
        USR_RSTN   = 1'b1;
        CLR_LOST   = 1'b0;
        tick(2);
        RST = 1'b0;
    endtask

    // Edge n after release with lock stable high: WAIT 1..2, FILTER 3..6, HOLD 7..14, RUN 15+.
    function automatic logic [2:0] pwr_state(input int n);
        if (n <= 2)  return 3'd1;
        if (n <= 6)  return 3'd2;
        if (n <= 14) return 3'd3;
        return 3'd4;
    endfunction

    task automatic test_reset;
        RST = 1'b1; PLL_LOCKED = 1'b1; USR_RSTN = 1'b1; CLR_LOST = 1'b0;
        tick(2);
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL reset_sys_rst got=%b exp=1", sys_rst); end
        total++; if (rst_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", rst_done); end
        total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL reset_lost got=%b exp=0", lock_lost); end
        total++; if (stdy !== 1'b0) begin bad++; $display("FAIL reset_stdy got=%b exp=0", stdy); end
        total++; if (state0 !== 3'd0 || sys_rst0 !== 1'b1) begin bad++; $display("FAIL reset_dut0 state=%0d sys_rst=%b exp=0/1", state0, sys_rst0); end
        RST = 1'b0;
    endtask

    task automatic test_power_up;
        apply_reset(1'b1);
        for (int n = 1; n <= 15; n++) begin
            tick(1);
            total++;
            if (state !== pwr_state(n)) begin bad++; $display("FAIL pwr_state edge=%0d got=%0d exp=%0d", n, state, pwr_state(n)); end
            total++;
            if (sys_rst !== (n < 15) || rst_done !== (n >= 15)) begin
                bad++; $display("FAIL pwr_outputs edge=%0d sys_rst=%b done=%b exp=%b/%b", n, sys_rst, rst_done, n < 15, n >= 15);
            end
        end
    endtask

    task automatic test_filter_abort;
        apply_reset(1'b0);
        PLL_LOCKED = 1'b1;
        tick(3);
        total++; if (state !== 3'd2) begin bad++; $display("FAIL abort_enter_filter got=%0d exp=2", state); end
        PLL_LOCKED = 1'b0;
        tick(2);
        total++; if (state !== 3'd2) begin bad++; $display("FAIL abort_still_filter got=%0d exp=2", state); end
        tick(1);
        total++; if (state !== 3'd1) begin bad++; $display("FAIL abort_state got=%0d exp=1", state); end
        total++; if (sys_rst !== 1'b1 || lock_lost !== 1'b0) begin bad++; $display("FAIL abort_outputs sys_rst=%b lost=%b exp=1/0", sys_rst, lock_lost); end
        tick(5);
        total++; if (state !== 3'd1 || sys_rst !== 1'b1) begin bad++; $display("FAIL abort_stays_wait state=%0d sys_rst=%b exp=1/1", state, sys_rst); end
    endtask

    task automatic test_lock_loss;
        apply_reset(1'b1);
        tick(15);
        total++; if (state !== 3'd4) begin bad++; $display("FAIL loss_pre_run got=%0d exp=4", state); end
        PLL_LOCKED = 1'b0;
        tick(2);
        total++; if (state !== 3'd4 || stdy !== 1'b0) begin bad++; $display("FAIL loss_sync_delay state=%0d stdy=%b exp=4/0", state, stdy); end
        tick(1);
        total++; if (state !== 3'd1) begin bad++; $display("FAIL loss_state got=%0d exp=1", state); end
        total++; if (sys_rst !== 1'b1 || rst_done !== 1'b0) begin bad++; $display("FAIL loss_sys_rst sys_rst=%b done=%b exp=1/0", sys_rst, rst_done); end
        total++; if (lock_lost !== 1'b1) begin bad++; $display("FAIL loss_flag got=%b exp=1", lock_lost); end
        total++; if (stdy !== 1'b1) begin bad++; $display("FAIL loss_stdy_pulse got=%b exp=1", stdy); end
        tick(1);
        total++; if (stdy !== 1'b0) begin bad++; $display("FAIL loss_stdy_width got=%b exp=0", stdy); end
        total++; if (lock_lost !== 1'b1) begin bad++; $display("FAIL loss_sticky got=%b exp=1", lock_lost); end
        PLL_LOCKED = 1'b1;
        tick(14);
        total++; if (state !== 3'd3) begin bad++; $display("FAIL relock_hold got=%0d exp=3", state); end
        tick(1);
        total++; if (state !== 3'd4 || rst_done !== 1'b1) begin bad++; $display("FAIL relock_run state=%0d done=%b exp=4/1", state, rst_done); end
`ifdef PLL_LOSS_CNT_EN
        total++; if (loss_cnt !== 8'd1) begin bad++; $display("FAIL loss_cnt_one got=%0d exp=1", loss_cnt); end
`endif
    endtask

    task automatic test_clr_lost;
        CLR_LOST = 1'b1;
        tick(1);
        CLR_LOST = 1'b0;
        total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL clr_lost got=%b exp=0", lock_lost); end
        // Clear held through a fresh loss event: the set must win on that edge.
        CLR_LOST = 1'b1;
        PLL_LOCKED = 1'b0;
        tick(3);
        total++; if (lock_lost !== 1'b1 || state !== 3'd1) begin bad++; $display("FAIL set_wins lost=%b state=%0d exp=1/1", lock_lost, state); end
        tick(1);
        total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL clr_after_set got=%b exp=0", lock_lost); end
        CLR_LOST = 1'b0;
        PLL_LOCKED = 1'b1;
    endtask

    task automatic test_usr_and_loss;
        apply_reset(1'b1);
        tick(15);
        USR_RSTN = 1'b0;
        PLL_LOCKED = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            tick(1);
            total++;
            if (stdy !== 1'b0) begin bad++; $display("FAIL usr_no_stdy edge=%0d got=%b exp=0", n, stdy); end
        end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL usr_state got=%0d exp=0", state); end
        total++; if (lock_lost !== 1'b0 || sys_rst !== 1'b1) begin bad++; $display("FAIL usr_outputs lost=%b sys_rst=%b exp=0/1", lock_lost, sys_rst); end
        USR_RSTN = 1'b1;
        PLL_LOCKED = 1'b1;
        tick(2);
        total++; if (state !== 3'd0) begin bad++; $display("FAIL usr_release_delay got=%0d exp=0", state); end
        tick(1);
        total++; if (state !== 3'd1) begin bad++; $display("FAIL usr_release got=%0d exp=1", state); end
    endtask

    task automatic test_mid_reset;
        apply_reset(1'b1);
        tick(9);
        total++; if (state !== 3'd3) begin bad++; $display("FAIL mid_pre_hold got=%0d exp=3", state); end
        #2 RST = 1'b1;
        #1;
        total++; if (state !== 3'd0 || sys_rst !== 1'b1) begin bad++; $display("FAIL mid_async state=%0d sys_rst=%b exp=0/1", state, sys_rst); end
        tick(1);
        RST = 1'b0;
        tick(14);
        total++; if (state !== 3'd3 || sys_rst !== 1'b1) begin bad++; $display("FAIL mid_restart_hold state=%0d sys_rst=%b exp=3/1", state, sys_rst); end
        tick(1);
        total++; if (state !== 3'd4 || sys_rst !== 1'b0) begin bad++; $display("FAIL mid_restart_run state=%0d sys_rst=%b exp=4/0", state, sys_rst); end
    endtask

    task automatic test_lock_req0;
        apply_reset(1'b0);
        tick(1);
        total++; if (state0 !== 3'd1) begin bad++; $display("FAIL nolock_wait got=%0d exp=1", state0); end
        tick(1);
        total++; if (state0 !== 3'd3) begin bad++; $display("FAIL nolock_hold got=%0d exp=3", state0); end
        tick(7);
        total++; if (state0 !== 3'd3 || sys_rst0 !== 1'b1) begin bad++; $display("FAIL nolock_hold_end state=%0d sys_rst=%b exp=3/1", state0, sys_rst0); end
        tick(1);
        total++; if (state0 !== 3'd4 || sys_rst0 !== 1'b0 || rst_done0 !== 1'b1) begin
            bad++; $display("FAIL nolock_run state=%0d sys_rst=%b done=%b exp=4/0/1", state0, sys_rst0, rst_done0);
        end
        for (int n = 0; n < 20; n++) begin
            PLL_LOCKED = ~PLL_LOCKED;
            tick(1);
            total++;
            if (state0 !== 3'd4 || lock_lost0 !== 1'b0 || stdy0 !== 1'b0) begin
                bad++; $display("FAIL nolock_toggle n=%0d state=%0d lost=%b stdy=%b exp=4/0/0", n, state0, lock_lost0, stdy0);
            end
        end
    endtask

`ifdef PLL_LOSS_CNT_EN
    task automatic test_loss_cnt;
        apply_reset(1'b1);
        tick(15);
        for (int n = 1; n <= 300; n++) begin
            PLL_LOCKED = 1'b0;
            tick(3);
            PLL_LOCKED = 1'b1;
            tick(15);
            if (n == 255) begin
                total++; if (loss_cnt !== 8'd255) begin bad++; $display("FAIL loss_cnt_255 got=%0d exp=255", loss_cnt); end
            end
        end
        total++; if (loss_cnt !== 8'd255 || state !== 3'd4) begin bad++; $display("FAIL loss_cnt_sat cnt=%0d state=%0d exp=255/4", loss_cnt, state); end
        total++; if (loss_cnt0 !== 8'd0) begin bad++; $display("FAIL loss_cnt_dut0 got=%0d exp=0", loss_cnt0); end
        RST = 1'b1;
        #1;
        total++; if (loss_cnt !== 8'd0) begin bad++; $display("FAIL loss_cnt_rst got=%0d exp=0", loss_cnt); end
        tick(1);
        RST = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_power_up();
        test_filter_abort();
        test_lock_loss();
        test_clr_lost();
        test_usr_and_loss();
        test_mid_reset();
        test_lock_req0();
`ifdef PLL_LOSS_CNT_EN
        test_loss_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
